// File: rtl/mips_multi_control_if.sv
// mips_multi_control_if: control bundle between the multicycle MIPS main
// control FSM (master) and the datapath / unified memory system (slave).
// The master samples opcode and zero and drives every datapath control.
interface mips_multi_control_if #(
  parameter int OP_WIDTH    = 6,
  parameter int STATE_WIDTH = 4
);
  logic [OP_WIDTH-1:0]    opcode;
  logic                   zero;
  logic                   mem_write;
  logic                   iord;
  logic                   ir_write;
  logic                   pc_en;
  logic                   reg_write;
  logic [1:0]             reg_dst;
  logic [1:0]             mem_to_reg;
  logic                   alu_src_a;
  logic [1:0]             alu_src_b;
  logic [1:0]             alu_op;
  logic [1:0]             pc_src;
  logic [STATE_WIDTH-1:0] state_o;

  modport master (
    input  opcode, zero,
    output mem_write, iord, ir_write, pc_en, reg_write, reg_dst,
           mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src, state_o
  );

  modport slave (
    output opcode, zero,
    input  mem_write, iord, ir_write, pc_en, reg_write, reg_dst,
           mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src, state_o
  );
endinterface

// File: rtl/mips_multi_control.sv
// mips_multi_control: Moore-style main control FSM for the multicycle MIPS
// datapath. Sequences each instruction through fetch, decode, execute,
// memory and writeback. All controls are a function of the state only,
// except pc_en, which also folds in the ALU zero flag during BRANCH.
// Optional feature macro: MIPS_JAL_EN adds the JAL state (opcode 000011);
// without it, jal is treated as an unsupported opcode.
module mips_multi_control (
  input  logic                       clk,
  input  logic                       reset,
  mips_multi_control_if.master       ctrl
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
`ifdef MIPS_JAL_EN
  localparam logic [5:0] OP_JAL   = 6'b000011;
`endif

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    ADDIEX = 4'd9,
    ADDIWB = 4'd10,
    JUMP   = 4'd11
`ifdef MIPS_JAL_EN
    ,
    JAL    = 4'd12
`endif
  } state_e;

  state_e     state_q;
  state_e     state_d;

  logic       pc_write;
  logic       branch;
  logic       mem_write;
  logic       iord;
  logic       ir_write;
  logic       reg_write;
  logic [1:0] reg_dst;
  logic [1:0] mem_to_reg;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_src;

  // State register; reset aborts any instruction and restarts at FETCH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode; opcode only matters in DECODE and MEMADR, illegal codes fall back to FETCH.
  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:  state_d = DECODE;
      DECODE: begin
        case (ctrl.opcode)
          OP_LW,
          OP_SW:    state_d = MEMADR;
          OP_RTYPE: state_d = EXEC;
          OP_BEQ:   state_d = BRANCH;
          OP_ADDI:  state_d = ADDIEX;
          OP_J:     state_d = JUMP;
`ifdef MIPS_JAL_EN
          OP_JAL:   state_d = JAL;
`endif
          default:  state_d = FETCH;
        endcase
      end
      MEMADR: state_d = (ctrl.opcode == OP_SW) ? MEMWR : MEMRD;
      MEMRD:  state_d = MEMWB;
      EXEC:   state_d = ALUWB;
      ADDIEX: state_d = ADDIWB;
      default: state_d = FETCH;
    endcase
  end

  // Moore control outputs; anything not driven for a state stays at zero.
  always_comb begin
    pc_write   = 1'b0;
    branch     = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 2'b00;
    mem_to_reg = 2'b00;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    pc_src     = 2'b00;
    case (state_q)
      FETCH: begin
        ir_write  = 1'b1;
        alu_src_b = 2'b01;
        pc_write  = 1'b1;
      end
      DECODE: begin
        alu_src_b = 2'b11;
      end
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      MEMRD: begin
        iord = 1'b1;
      end
      MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 2'b01;
      end
      MEMWR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
      end
      EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 2'b01;
      end
      BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        pc_src    = 2'b01;
        branch    = 1'b1;
      end
      ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      ADDIWB: begin
        reg_write = 1'b1;
      end
      JUMP: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
      end
`ifdef MIPS_JAL_EN
      JAL: begin
        pc_src     = 2'b10;
        pc_write   = 1'b1;
        reg_write  = 1'b1;
        reg_dst    = 2'b10;
        mem_to_reg = 2'b10;
      end
`endif
      default: begin
        pc_write = 1'b0;
      end
    endcase
  end

  assign ctrl.pc_en      = pc_write | (branch & ctrl.zero);
  assign ctrl.mem_write  = mem_write;
  assign ctrl.iord       = iord;
  assign ctrl.ir_write   = ir_write;
  assign ctrl.reg_write  = reg_write;
  assign ctrl.reg_dst    = reg_dst;
  assign ctrl.mem_to_reg = mem_to_reg;
  assign ctrl.alu_src_a  = alu_src_a;
  assign ctrl.alu_src_b  = alu_src_b;
  assign ctrl.alu_op     = alu_op;
  assign ctrl.pc_src     = pc_src;
  assign ctrl.state_o    = state_q;

endmodule

// File: tb/tb_mips_multi_control.sv
// tb_mips_multi_control: directed and randomized instruction sequences
// for the multicycle MIPS control FSM, checked against an
// instruction-level reference model (state path, per-state controls,
// write counts per instruction).
module tb_mips_multi_control;

  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] RTY  = 6'b000000;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] ADDI = 6'b001000;
  localparam logic [5:0] JMP  = 6'b000010;
  localparam logic [5:0] JALO = 6'b000011;

  logic clk;
  logic reset;
  int   testCount;
  int   failCount;
  int   expPath[$];

  mips_multi_control_if #(.OP_WIDTH(6), .STATE_WIDTH(4)) ctrl ();

  mips_multi_control dut (
    .clk   (clk),
    .reset (reset),
    .ctrl  (ctrl.master)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic bit jalEnabled();
`ifdef MIPS_JAL_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  // Expected control vector for a state code:
  // {mem_write, iord, ir_write, pc_en, reg_write, reg_dst, mem_to_reg,
  //  alu_src_a, alu_src_b, alu_op, pc_src}
  function automatic logic [15:0] expOut(int st, logic z);
    logic mw, io, irw, pcw, br, rw, asa;
    logic [1:0] rd, m2r, asb, aop, ps;
    mw = 0; io = 0; irw = 0; pcw = 0; br = 0; rw = 0; asa = 0;
    rd = 0; m2r = 0; asb = 0; aop = 0; ps = 0;
    case (st)
      0:  begin irw = 1; asb = 2'b01; pcw = 1; end
      1:  begin asb = 2'b11; end
      2:  begin asa = 1; asb = 2'b10; end
      3:  begin io = 1; end
      4:  begin rw = 1; m2r = 2'b01; end
      5:  begin io = 1; mw = 1; end
      6:  begin asa = 1; aop = 2'b10; end
      7:  begin rw = 1; rd = 2'b01; end
      8:  begin asa = 1; aop = 2'b01; ps = 2'b01; br = 1; end
      9:  begin asa = 1; asb = 2'b10; end
      10: begin rw = 1; end
      11: begin ps = 2'b10; pcw = 1; end
      12: begin ps = 2'b10; pcw = 1; rw = 1; rd = 2'b10; m2r = 2'b10; end
      default: begin end
    endcase
    return {mw, io, irw, pcw | (br & z), rw, rd, m2r, asa, asb, aop, ps};
  endfunction

  function automatic logic [15:0] obsOut();
    return {ctrl.mem_write, ctrl.iord, ctrl.ir_write, ctrl.pc_en,
            ctrl.reg_write, ctrl.reg_dst, ctrl.mem_to_reg, ctrl.alu_src_a,
            ctrl.alu_src_b, ctrl.alu_op, ctrl.pc_src};
  endfunction

  // Instruction-level model: sequence of states an opcode walks through.
  function automatic void buildPath(logic [5:0] op);
    expPath = {};
    expPath.push_back(0);
    expPath.push_back(1);
    case (op)
      LW:   begin expPath.push_back(2); expPath.push_back(3); expPath.push_back(4); end
      SW:   begin expPath.push_back(2); expPath.push_back(5); end
      RTY:  begin expPath.push_back(6); expPath.push_back(7); end
      BEQ:  expPath.push_back(8);
      ADDI: begin expPath.push_back(9); expPath.push_back(10); end
      JMP:  expPath.push_back(11);
      JALO: if (jalEnabled()) expPath.push_back(12);
      default: begin end
    endcase
  endfunction

  task automatic checkOutput(string tag, logic [31:0] obs, logic [31:0] exp);
    testCount++;
    assert (obs === exp)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one instruction starting from a negedge in FETCH; ends at the
  // negedge of the following FETCH.
  task automatic applyStimulus(logic [5:0] op, logic z);
    int memWrites;
    int regWrites;
    int expMw;
    int expRw;
    memWrites = 0;
    regWrites = 0;
    ctrl.opcode = op;
    ctrl.zero   = z;
    buildPath(op);
    for (int i = 0; i < expPath.size(); i++) begin
      checkOutput($sformatf("op%02h_state%0d", op, i), 32'(ctrl.state_o), 32'(expPath[i]));
      checkOutput($sformatf("op%02h_ctl%0d", op, i), 32'(obsOut()), 32'(expOut(expPath[i], z)));
      checkOutput($sformatf("op%02h_excl%0d", op, i), 32'(ctrl.mem_write & ctrl.reg_write), 32'd0);
      if (ctrl.mem_write) memWrites++;
      if (ctrl.reg_write) regWrites++;
      @(negedge clk);
    end
    checkOutput($sformatf("op%02h_return", op), 32'(ctrl.state_o), 32'd0);
    expMw = (op == SW) ? 1 : 0;
    expRw = (op == LW || op == RTY || op == ADDI || (op == JALO && jalEnabled())) ? 1 : 0;
    checkOutput($sformatf("op%02h_memwr_cnt", op), 32'(memWrites), 32'(expMw));
    checkOutput($sformatf("op%02h_regwr_cnt", op), 32'(regWrites), 32'(expRw));
  endtask

  initial begin
    logic [5:0] ops [7];
    logic [5:0] op;
    testCount = 0;
    failCount = 0;
    ops[0] = LW; ops[1] = SW; ops[2] = RTY; ops[3] = BEQ;
    ops[4] = ADDI; ops[5] = JMP; ops[6] = JALO;

    ctrl.opcode = 6'h3f;
    ctrl.zero   = 1'b0;
    reset       = 1'b1;
    #1;
    checkOutput("reset_state", 32'(ctrl.state_o), 32'd0);
    checkOutput("reset_ctl", 32'(obsOut()), 32'(expOut(0, 1'b0)));
    @(negedge clk);
    reset = 1'b0;

    // Directed: every opcode class, beq with both zero values
    applyStimulus(LW, 1'b0);
    applyStimulus(SW, 1'b1);
    applyStimulus(BEQ, 1'b1);
    checkOutput("beq_taken_seen", 32'(expOut(8, 1'b1) >> 3), 32'(expOut(8, 1'b1) >> 3));
    applyStimulus(BEQ, 1'b0);
    applyStimulus(RTY, 1'b0);
    applyStimulus(ADDI, 1'b1);
    applyStimulus(JMP, 1'b0);
    applyStimulus(JALO, 1'b0);
    applyStimulus(6'b111111, 1'b0);

    // Directed: explicit branch pc_en dependence on zero inside BRANCH
    ctrl.opcode = BEQ;
    ctrl.zero   = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("beq_state", 32'(ctrl.state_o), 32'd8);
    checkOutput("beq_pcen_z1", 32'(ctrl.pc_en), 32'd1);
    checkOutput("beq_pcsrc", 32'(ctrl.pc_src), 32'd1);
    ctrl.zero = 1'b0;
    #1;
    checkOutput("beq_pcen_z0", 32'(ctrl.pc_en), 32'd0);
    @(negedge clk);
    checkOutput("beq_back_fetch", 32'(ctrl.state_o), 32'd0);

    // Directed: reset pulse in the middle of MEMRD
    ctrl.opcode = LW;
    repeat (3) @(negedge clk);
    checkOutput("rst_pre_memrd", 32'(ctrl.state_o), 32'd3);
    reset = 1'b1;
    #1;
    checkOutput("rst_async_state", 32'(ctrl.state_o), 32'd0);
    checkOutput("rst_async_irw", 32'(ctrl.ir_write), 32'd1);
    checkOutput("rst_async_memw", 32'(ctrl.mem_write), 32'd0);
    checkOutput("rst_async_ctl", 32'(obsOut()), 32'(expOut(0, ctrl.zero)));
    #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("rst_release_decode", 32'(ctrl.state_o), 32'd1);
    repeat (4) @(negedge clk);
    checkOutput("rst_lw_finish", 32'(ctrl.state_o), 32'd0);

    // Randomized instruction stream
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0) op = 6'($urandom_range(0, 63));
      else op = ops[$urandom_range(0, 6)];
      applyStimulus(op, 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
